// File: rtl/ias_memory_responder.sv
// ias_memory_responder: main-memory target with a fixed-latency valid/ready request/response handshake
module ias_memory_responder #(
  parameter int DATA_W  = 40,
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 1000,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              commit, c_we, c_in;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  assign req_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  // next state, request capture and the response commit; with LATENCY 1 the commit uses the live request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    c_we    = state_q == IDLE ? req_we : we_q;
    c_addr  = state_q == IDLE ? req_addr : addr_q;
    c_wdata = state_q == IDLE ? req_wdata : wdata_q;
    c_in    = 32'(c_addr) < DEPTH;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        cnt_d   = 4'(LATENCY - 1);
        state_d = LATENCY == 1 ? RESP : WAIT;
        commit  = LATENCY == 1;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      err_d   = !c_in;
      rdata_d = !c_in ? '0 : c_we ? c_wdata : mem[c_addr[IW-1:0]];
    end
  end
  // control and response registers; reset clears everything except the array
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // array write on the commit edge; a reset on that edge suppresses it
  always_ff @(posedge clk) begin
    if (reset && commit && c_we && c_in) mem[c_addr[IW-1:0]] <= c_wdata;
  end
endmodule
